// File: rtl/line_fifo_writer_if.sv
// Video-in, crop window, reader pop and line-RAM write/status signals of line_fifo_writer.
// master = video source / reader side, slave = line_fifo_writer.
interface line_fifo_writer_if #(
    parameter int DATA_WIDTH        = 24,
    parameter int ADDRESS_WIDTH     = 11,
    parameter int INPUT_RES_WIDTH   = 11,
    parameter int BUFFER_SIZE       = 4,
    parameter int BUFFER_SIZE_WIDTH = (BUFFER_SIZE > 2) ? $clog2(BUFFER_SIZE) : 1
);
    logic                         dInEn;
    logic [DATA_WIDTH-1:0]        dIn;
    logic                         hsIn;
    logic                         vsIn;
    logic [INPUT_RES_WIDTH-1:0]   xBgn;
    logic [INPUT_RES_WIDTH-1:0]   xEnd;
    logic [INPUT_RES_WIDTH-1:0]   yBgn;
    logic [INPUT_RES_WIDTH-1:0]   yEnd;
    logic                         jmp1;
    logic                         jmp2;
    logic                         ramWrEn;
    logic [ADDRESS_WIDTH-1:0]     ramWrAddr;
    logic [DATA_WIDTH-1:0]        ramWrData;
    logic [BUFFER_SIZE_WIDTH-1:0] wrLine;
    logic [BUFFER_SIZE_WIDTH-1:0] rdLine;
    logic [BUFFER_SIZE_WIDTH:0]   fifoNum;
    logic [INPUT_RES_WIDTH-1:0]   inXNum;
    logic [INPUT_RES_WIDTH-1:0]   inYNum;
    logic                         overflow;
    logic                         frameDone;

    modport master (
        output dInEn, dIn, hsIn, vsIn, xBgn, xEnd, yBgn, yEnd, jmp1, jmp2,
        input  ramWrEn, ramWrAddr, ramWrData, wrLine, rdLine, fifoNum,
               inXNum, inYNum, overflow, frameDone
    );

    modport slave (
        input  dInEn, dIn, hsIn, vsIn, xBgn, xEnd, yBgn, yEnd, jmp1, jmp2,
        output ramWrEn, ramWrAddr, ramWrData, wrLine, rdLine, fifoNum,
               inXNum, inYNum, overflow, frameDone
    );
endinterface

// File: rtl/line_fifo_writer.sv
// Crops incoming video to a window and writes each kept row into a ring of line RAMs,
// tracking committed lines as a FIFO that the reader pops one or two lines at a time.
//
// state   | meaning
// WAIT_VS | idle after reset, pixels and hsIn ignored until the first vsIn
// RUN     | counting pixels/rows of the current frame and writing the crop window
module line_fifo_writer #(
    parameter int DATA_WIDTH        = 24,
    parameter int ADDRESS_WIDTH     = 11,
    parameter int INPUT_RES_WIDTH   = 11,
    parameter int BUFFER_SIZE       = 4,
    parameter int BUFFER_SIZE_WIDTH = (BUFFER_SIZE > 2) ? $clog2(BUFFER_SIZE) : 1
) (
    input logic               clk,
    input logic               rst,
    line_fifo_writer_if.slave bus
);
    localparam int XW = INPUT_RES_WIDTH;
    localparam int BW = BUFFER_SIZE_WIDTH;
    localparam int FW = BUFFER_SIZE_WIDTH + 1;
    localparam logic [FW-1:0] FULL    = FW'(BUFFER_SIZE);
    localparam logic [XW-1:0] CNT_MAX = '1;

    typedef enum logic {WAIT_VS = 1'b0, RUN = 1'b1} state_t;
    state_t state_q, state_d;
    logic   run;

    logic [XW-1:0]            xbgn_q, xend_q, ybgn_q, yend_q, xcnt_q, ycnt_q;
    logic                     drop_row_q, row_has_q, overflow_q, frame_done_q, ram_wr_en_q;
    logic [ADDRESS_WIDTH-1:0] ram_wr_addr_q;
    logic [DATA_WIDTH-1:0]    ram_wr_data_q;
    logic [BW-1:0]            wr_line_q, wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [FW-1:0]            fifo_num_q, fifo_num_d, pop_req, pop, wr_sum, rd_sum;
    logic                     accept, full, wr_now, hs, drop_now, commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= WAIT_VS;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.vsIn) state_d = RUN;
    end

    // vsIn takes priority over any pixel or hsIn arriving with it
    always_comb begin
        run = (state_q == RUN) && !bus.vsIn;
    end

    always_comb begin
        accept   = run && bus.dInEn
                   && (xcnt_q >= xbgn_q) && (xcnt_q <= xend_q)
                   && (ycnt_q >= ybgn_q) && (ycnt_q <= yend_q);
        full     = (fifo_num_q == FULL);
        wr_now   = accept && !full && !drop_row_q;
        hs       = run && bus.hsIn;
        drop_now = drop_row_q || (accept && full);
        commit   = hs && (row_has_q || accept) && !drop_now;

        pop_req = '0;
        if (bus.jmp2)      pop_req = FW'(2);
        else if (bus.jmp1) pop_req = FW'(1);
        pop = (pop_req > fifo_num_q) ? fifo_num_q : pop_req;

        fifo_num_d = fifo_num_q + FW'(commit) - pop;

        wr_sum = {1'b0, wr_ptr_q} + FW'(commit);
        if (wr_sum >= FULL) wr_sum = wr_sum - FULL;
        wr_ptr_d = wr_sum[BW-1:0];

        rd_sum = {1'b0, rd_ptr_q} + pop;
        if (rd_sum >= FULL) rd_sum = rd_sum - FULL;
        rd_ptr_d = rd_sum[BW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xbgn_q        <= '0;
            xend_q        <= '0;
            ybgn_q        <= '0;
            yend_q        <= '0;
            xcnt_q        <= '0;
            ycnt_q        <= '0;
            drop_row_q    <= 1'b0;
            row_has_q     <= 1'b0;
            overflow_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            ram_wr_en_q   <= 1'b0;
            ram_wr_addr_q <= '0;
            ram_wr_data_q <= '0;
            wr_line_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_num_q    <= '0;
        end else begin
            fifo_num_q   <= fifo_num_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_wr_en_q  <= wr_now;
            frame_done_q <= hs && (ycnt_q == yend_q);
            if (wr_now) begin
                ram_wr_addr_q <= ADDRESS_WIDTH'(xcnt_q - xbgn_q);
                ram_wr_data_q <= bus.dIn;
                wr_line_q     <= wr_ptr_q;
            end
            if (bus.vsIn) begin
                xbgn_q     <= bus.xBgn;
                xend_q     <= bus.xEnd;
                ybgn_q     <= bus.yBgn;
                yend_q     <= bus.yEnd;
                xcnt_q     <= '0;
                ycnt_q     <= '0;
                overflow_q <= 1'b0;
                drop_row_q <= 1'b0;
                row_has_q  <= 1'b0;
            end else if (run) begin
                if (hs) begin
                    xcnt_q     <= '0;
                    drop_row_q <= 1'b0;
                    row_has_q  <= 1'b0;
                    if (ycnt_q != CNT_MAX) ycnt_q <= ycnt_q + 1'b1;
                end else begin
                    if (bus.dInEn && (xcnt_q != CNT_MAX)) xcnt_q <= xcnt_q + 1'b1;
                    if (accept)         row_has_q  <= 1'b1;
                    if (accept && full) drop_row_q <= 1'b1;
                end
                if (accept && full) overflow_q <= 1'b1;
            end
        end
    end

    assign bus.ramWrEn   = ram_wr_en_q;
    assign bus.ramWrAddr = ram_wr_addr_q;
    assign bus.ramWrData = ram_wr_data_q;
    assign bus.wrLine    = wr_line_q;
    assign bus.rdLine    = rd_ptr_q;
    assign bus.fifoNum   = fifo_num_q;
    assign bus.inXNum    = xend_q - xbgn_q;
    assign bus.inYNum    = yend_q - ybgn_q;
    assign bus.overflow  = overflow_q;
    assign bus.frameDone = frame_done_q;
endmodule

// File: tb/tb_line_fifo_writer.sv
// Directed bench for line_fifo_writer: a table of frame/row/pop operations with
// hand-computed results, plus short sequences for reset, mid-row vsIn and hsIn+pixel.
module tb_line_fifo_writer;
    localparam int DW = 24, AW = 11, RW = 11, BS = 4;
    localparam int OP_VS = 0, OP_ROW = 1, OP_POP = 2;
    localparam int NV = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_fifo_writer_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .INPUT_RES_WIDTH(RW),
                          .BUFFER_SIZE(BS)) bus ();

    line_fifo_writer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .INPUT_RES_WIDTH(RW),
                       .BUFFER_SIZE(BS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int op;  int npix; int j1;  int j2;
        int xb;  int xe;   int yb;  int ye;
        int wr;  int a0;   int a1;  int line;
        int fd;  int fifo; int rd;  int ovf;
        int xnum; int ynum;
    } vec_t;

    vec_t tbl [NV];
    vec_t v;
    int checks = 0;
    int errors = 0;
    int cur_y  = 0;
    int sh_xb  = 0;
    int nwr, a0, a1, line, fd, clean;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_row(input int npix, input int j1, input int j2,
                          output int o_wr, output int o_a0, output int o_a1,
                          output int o_line, output int o_fd, output int o_clean);
        logic [DW-1:0] exp_d;
        o_wr = 0; o_a0 = -1; o_a1 = -1; o_line = -1; o_clean = 1;
        for (int i = 0; i < npix; i++) begin
            bus.dInEn = 1'b1;
            bus.dIn   = 24'hA00000 | DW'(cur_y << 8) | DW'(i);
            tick();
            if (bus.frameDone) o_clean = 0;
            if (bus.ramWrEn) begin
                o_wr++;
                if (o_a0 < 0) o_a0 = int'(bus.ramWrAddr);
                o_a1   = int'(bus.ramWrAddr);
                o_line = int'(bus.wrLine);
                exp_d  = 24'hA00000 | DW'(cur_y << 8) | DW'(int'(bus.ramWrAddr) + sh_xb);
                if (bus.ramWrData != exp_d) o_clean = 0;
            end
        end
        bus.dInEn = 1'b0;
        bus.hsIn  = 1'b1;
        bus.jmp1  = j1[0];
        bus.jmp2  = j2[0];
        tick();
        o_fd = int'(bus.frameDone);
        if (bus.ramWrEn) o_wr++;
        bus.hsIn = 1'b0;
        bus.jmp1 = 1'b0;
        bus.jmp2 = 1'b0;
        cur_y++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ramWrEn"},   int'(bus.ramWrEn),   0);
        chk({tag, " ramWrAddr"}, int'(bus.ramWrAddr), 0);
        chk({tag, " ramWrData"}, int'(bus.ramWrData), 0);
        chk({tag, " wrLine"},    int'(bus.wrLine),    0);
        chk({tag, " rdLine"},    int'(bus.rdLine),    0);
        chk({tag, " fifoNum"},   int'(bus.fifoNum),   0);
        chk({tag, " inXNum"},    int'(bus.inXNum),    0);
        chk({tag, " inYNum"},    int'(bus.inYNum),    0);
        chk({tag, " overflow"},  int'(bus.overflow),  0);
        chk({tag, " frameDone"}, int'(bus.frameDone), 0);
    endtask

    initial begin
        //          op      np j1 j2  xb xe yb ye  wr a0 a1 ln  fd ff rd ov  xn yn
        tbl[0]  = '{OP_VS,  0, 0, 0,  2, 5, 1, 2,  0, 0, 0, 0,  0, 0, 0, 0,  3, 1};
        tbl[1]  = '{OP_ROW, 8, 0, 0,  2, 5, 1, 2,  0, 0, 0, 0,  0, 0, 0, 0,  3, 1};
        tbl[2]  = '{OP_ROW, 8, 0, 0,  2, 5, 1, 2,  4, 0, 3, 0,  0, 1, 0, 0,  3, 1};
        tbl[3]  = '{OP_ROW, 8, 0, 0,  2, 5, 1, 2,  4, 0, 3, 1,  1, 2, 0, 0,  3, 1};
        tbl[4]  = '{OP_ROW, 8, 0, 0,  2, 5, 1, 2,  0, 0, 0, 0,  0, 2, 0, 0,  3, 1};
        tbl[5]  = '{OP_VS,  0, 0, 0,  2, 5, 0, 3,  0, 0, 0, 0,  0, 2, 0, 0,  3, 3};
        tbl[6]  = '{OP_ROW, 8, 0, 0,  2, 5, 0, 3,  4, 0, 3, 2,  0, 3, 0, 0,  3, 3};
        tbl[7]  = '{OP_ROW, 8, 0, 0,  2, 5, 0, 3,  4, 0, 3, 3,  0, 4, 0, 0,  3, 3};
        tbl[8]  = '{OP_ROW, 8, 0, 0,  2, 5, 0, 3,  0, 0, 0, 0,  0, 4, 0, 1,  3, 3};
        tbl[9]  = '{OP_POP, 0, 1, 0,  2, 5, 0, 3,  0, 0, 0, 0,  0, 3, 1, 1,  3, 3};
        tbl[10] = '{OP_ROW, 8, 0, 0,  2, 5, 0, 3,  4, 0, 3, 0,  1, 4, 1, 1,  3, 3};
        tbl[11] = '{OP_VS,  0, 0, 0,  2, 5, 0, 3,  0, 0, 0, 0,  0, 4, 1, 0,  3, 3};
        tbl[12] = '{OP_POP, 0, 0, 1,  2, 5, 0, 3,  0, 0, 0, 0,  0, 2, 3, 0,  3, 3};
        tbl[13] = '{OP_POP, 0, 1, 0,  2, 5, 0, 3,  0, 0, 0, 0,  0, 1, 0, 0,  3, 3};
        tbl[14] = '{OP_POP, 0, 1, 1,  2, 5, 0, 3,  0, 0, 0, 0,  0, 0, 1, 0,  3, 3};
        tbl[15] = '{OP_POP, 0, 1, 0,  2, 5, 0, 3,  0, 0, 0, 0,  0, 0, 1, 0,  3, 3};
        tbl[16] = '{OP_ROW, 8, 1, 0,  2, 5, 0, 3,  4, 0, 3, 1,  0, 1, 1, 0,  3, 3};
        tbl[17] = '{OP_ROW, 8, 0, 0,  2, 5, 0, 3,  4, 0, 3, 2,  0, 2, 1, 0,  3, 3};
        tbl[18] = '{OP_ROW, 8, 0, 0,  2, 5, 0, 3,  4, 0, 3, 3,  0, 3, 1, 0,  3, 3};
        tbl[19] = '{OP_ROW, 8, 0, 1,  2, 5, 0, 3,  4, 0, 3, 0,  1, 2, 3, 0,  3, 3};
        tbl[20] = '{OP_VS,  0, 0, 0,  2, 5, 0, 1,  0, 0, 0, 0,  0, 2, 3, 0,  3, 1};
        tbl[21] = '{OP_ROW, 8, 0, 0,  2, 9, 0, 1,  4, 0, 3, 1,  0, 3, 3, 0,  3, 1};
        tbl[22] = '{OP_VS,  0, 0, 0,  2, 9, 0, 1,  0, 0, 0, 0,  0, 3, 3, 0,  7, 1};
        tbl[23] = '{OP_ROW,10, 0, 0,  2, 9, 0, 1,  8, 0, 7, 2,  0, 4, 3, 0,  7, 1};

        bus.dInEn = 1'b0; bus.dIn = '0; bus.hsIn = 1'b0; bus.vsIn = 1'b0;
        bus.jmp1 = 1'b0; bus.jmp2 = 1'b0;
        bus.xBgn = RW'(0); bus.xEnd = RW'(7); bus.yBgn = RW'(0); bus.yEnd = RW'(7);
        tick();
        tick();
        chk_reset_outputs("por");
        rst = 1'b0;
        tick();

        // pixels before any vsIn must be ignored
        do_row(8, 0, 0, nwr, a0, a1, line, fd, clean);
        chk("prevs writes", nwr, 0);
        chk("prevs fifoNum", int'(bus.fifoNum), 0);
        chk("prevs frameDone", fd, 0);

        for (int i = 0; i < NV; i++) begin
            v = tbl[i];
            bus.xBgn = RW'(v.xb); bus.xEnd = RW'(v.xe);
            bus.yBgn = RW'(v.yb); bus.yEnd = RW'(v.ye);
            nwr = 0; a0 = -1; a1 = -1; line = -1; fd = 0; clean = 1;
            case (v.op)
                OP_VS: begin
                    bus.vsIn = 1'b1;
                    tick();
                    bus.vsIn = 1'b0;
                    sh_xb = v.xb;
                    cur_y = 0;
                    nwr = int'(bus.ramWrEn);
                    fd  = int'(bus.frameDone);
                end
                OP_ROW: do_row(v.npix, v.j1, v.j2, nwr, a0, a1, line, fd, clean);
                default: begin
                    bus.jmp1 = v.j1[0];
                    bus.jmp2 = v.j2[0];
                    tick();
                    bus.jmp1 = 1'b0;
                    bus.jmp2 = 1'b0;
                    nwr = int'(bus.ramWrEn);
                    fd  = int'(bus.frameDone);
                end
            endcase
            chk($sformatf("v%0d writes", i), nwr, v.wr);
            if (v.wr > 0) begin
                chk($sformatf("v%0d first addr", i), a0, v.a0);
                chk($sformatf("v%0d last addr", i), a1, v.a1);
                chk($sformatf("v%0d wrLine", i), line, v.line);
                chk($sformatf("v%0d data/pulse", i), clean, 1);
            end
            chk($sformatf("v%0d frameDone", i), fd, v.fd);
            chk($sformatf("v%0d fifoNum", i), int'(bus.fifoNum), v.fifo);
            chk($sformatf("v%0d rdLine", i), int'(bus.rdLine), v.rd);
            chk($sformatf("v%0d overflow", i), int'(bus.overflow), v.ovf);
            chk($sformatf("v%0d inXNum", i), int'(bus.inXNum), v.xnum);
            chk($sformatf("v%0d inYNum", i), int'(bus.inYNum), v.ynum);
        end

        // rst mid-row with lines committed: takes effect without a clock edge
        for (int i = 0; i < 3; i++) begin
            bus.dInEn = 1'b1;
            bus.dIn   = DW'(24'h0F0000 + i);
            tick();
        end
        chk("midrow overflow before rst", int'(bus.overflow), 1);
        rst = 1'b1;
        #2;
        chk_reset_outputs("async rst");
        bus.dInEn = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        bus.xBgn = RW'(0); bus.xEnd = RW'(7); bus.yBgn = RW'(0); bus.yEnd = RW'(7);
        do_row(6, 0, 0, nwr, a0, a1, line, fd, clean);
        chk("post rst writes", nwr, 0);
        chk("post rst fifoNum", int'(bus.fifoNum), 0);

        // vsIn mid-row throws the partial row away
        bus.vsIn = 1'b1; tick(); bus.vsIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.dInEn = 1'b1;
            bus.dIn   = DW'(24'h0E0000 + i);
            tick();
        end
        bus.dInEn = 1'b0;
        chk("partial row last addr", int'(bus.ramWrAddr), 2);
        bus.vsIn = 1'b1; tick(); bus.vsIn = 1'b0;
        bus.hsIn = 1'b1; tick(); bus.hsIn = 1'b0;
        chk("vs midrow fifoNum", int'(bus.fifoNum), 0);

        // pixel with hsIn in the same cycle is the last pixel of its row
        bus.dInEn = 1'b1; bus.hsIn = 1'b1; bus.dIn = 24'h123456;
        tick();
        bus.dInEn = 1'b0; bus.hsIn = 1'b0;
        chk("hs+pix ramWrEn", int'(bus.ramWrEn), 1);
        chk("hs+pix addr", int'(bus.ramWrAddr), 0);
        chk("hs+pix data", int'(bus.ramWrData), 32'h123456);
        chk("hs+pix wrLine", int'(bus.wrLine), 0);
        chk("hs+pix fifoNum", int'(bus.fifoNum), 1);
        tick();
        chk("hs+pix ramWrEn drop", int'(bus.ramWrEn), 0);
        chk("hs+pix addr hold", int'(bus.ramWrAddr), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
